// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and limits for the bit-serial adder controller.
// Holds the FSM state encoding, legal WIDTH range and counter sizing helper.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  // Bit counter needs at least one bit even when WIDTH is 1.
  function automatic int cnt_width(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the serial adder.
// Zero latency, no flow control.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ c;
  assign co  = (a & b) | (w_p & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB-first over WIDTH cycles.
// Result after WIDTH+1 edges from accept; in_ready low while RUN, out_valid pulses once.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_add_ctrl: WIDTH out of range 1..64");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_nxt;

  fa_cell u_fa (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .c  (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == LAST_BIT);

  // New sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  always_comb begin
    w_sum_nxt            = r_sum_sr >> 1;
    w_sum_nxt[WIDTH-1]   = w_s;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b1;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b0;
        busy     = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid   = 1'b1;
        w_state_nxt = in_valid ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= w_sum_nxt;
      r_carry  <= w_co;
      r_cnt    <= r_cnt + 1'b1;
      // Published result only moves on the final bit, so sum/cout hold across a run.
      if (w_last) begin
        r_sum  <= w_sum_nxt;
        r_cout <= w_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH 8, 1 and 16.
// Expected results come from plain a+b+cin arithmetic and an accept-to-result cycle model.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       iv8 = 1'b0, ir8, ov8, co8, busy8, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       iv1 = 1'b0, ir1, ov1, co1, busy1, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, s1;
  logic        iv16 = 1'b0, ir16, ov16, co16, busy16, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, s16;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .sum(s8), .cout(co8), .busy(busy8));

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .sum(s1), .cout(co1), .busy(busy1));

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .sum(s16), .cout(co16), .busy(busy16));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_tests++;
    if ({ir8, ov8, busy8, co8, s8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_w8 got ir=%b ov=%b busy=%b cout=%b sum=%h want 1 0 0 0 00",
               ir8, ov8, busy8, co8, s8);
    end
    n_tests++;
    if ({ir1, ov1, busy1, co1, s1, ir16, ov16, busy16, co16, s16} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_w1_w16 got w1 sum=%b cout=%b w16 sum=%h cout=%b ir16=%b want zeros, ready",
               s1, co1, s16, co16, ir16);
    end
  endtask

  task automatic test_vectors;
    logic [7:0] ta [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [7:0] tb [3] = '{8'h3C, 8'h01, 8'h00};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] prev = 9'h000;
    for (int v = 0; v < 3; v++) begin
      logic [8:0] exp = {1'b0, ta[v]} + {1'b0, tb[v]} + {8'h00, tc[v]};
      logic       lat_ok = 1'b1;
      a8 = ta[v]; b8 = tb[v]; cin8 = tc[v]; iv8 = 1'b1;
      for (int k = 1; k <= 9; k++) begin
        step();
        if (k == 1) iv8 = 1'b0;
        if (k <= 8 && {busy8, ir8, ov8} !== 3'b100) lat_ok = 1'b0;
        if (k == 4) begin
          n_tests++;
          if ({co8, s8} !== prev) begin
            n_fail++;
            $display("FAIL vec%0d_hold got %h want %h", v, {co8, s8}, prev);
          end
        end
      end
      n_tests++;
      if (!lat_ok || {busy8, ir8, ov8} !== 3'b011) begin
        n_fail++;
        $display("FAIL vec%0d_timing got busy/ir/ov=%b at edge 9 (run window ok=%b) want 011", v,
                 {busy8, ir8, ov8}, lat_ok);
      end
      n_tests++;
      if ({co8, s8} !== exp) begin
        n_fail++;
        $display("FAIL vec%0d_result got cout=%b sum=%h want cout=%b sum=%h", v, co8, s8, exp[8], exp[7:0]);
      end
      prev = exp;
    end
    step();
  endtask

  task automatic test_back_to_back;
    logic early_ov = 1'b0;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; iv8 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) begin a8 = 8'h01; b8 = 8'h01; end
      if (k < 9 && ov8 !== 1'b0) early_ov = 1'b1;
    end
    n_tests++;
    if ({ov8, ir8, co8, s8} !== {1'b1, 1'b1, 1'b0, 8'h30} || early_ov) begin
      n_fail++;
      $display("FAIL b2b_first got ov=%b ir=%b cout=%b sum=%h early=%b want 1 1 0 30 early=0",
               ov8, ir8, co8, s8, early_ov);
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) iv8 = 1'b0;
      if (k < 9 && ov8 !== 1'b0) early_ov = 1'b1;
    end
    n_tests++;
    if ({ov8, co8, s8} !== {1'b1, 1'b0, 8'h02} || early_ov) begin
      n_fail++;
      $display("FAIL b2b_second got ov=%b cout=%b sum=%h early=%b want 1 0 02 early=0",
               ov8, co8, s8, early_ov);
    end
    step();
  endtask

  task automatic test_reset_abort;
    logic stray_ov = 1'b0;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if ({ir8, busy8, ov8, co8, s8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL abort_state got ir=%b busy=%b ov=%b cout=%b sum=%h want 1 0 0 0 00",
               ir8, busy8, ov8, co8, s8);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      if (ov8 !== 1'b0) stray_ov = 1'b1;
    end
    n_tests++;
    if (stray_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_pulse got stray out_valid=%b want 0", stray_ov);
    end
    a8 = 8'h01; b8 = 8'h02; iv8 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) iv8 = 1'b0;
    end
    n_tests++;
    if ({ov8, co8, s8} !== {1'b1, 1'b0, 8'h03}) begin
      n_fail++;
      $display("FAIL abort_fresh got ov=%b cout=%b sum=%h want 1 0 03", ov8, co8, s8);
    end
    step();
  endtask

  task automatic test_width1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v = 3'(i);
      logic [1:0] exp = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; iv1 = 1'b1;
      step();
      iv1 = 1'b0;
      n_tests++;
      if ({busy1, ov1} !== 2'b10) begin
        n_fail++;
        $display("FAIL w1_run%0d got busy=%b ov=%b want 1 0", i, busy1, ov1);
      end
      step();
      n_tests++;
      if ({ov1, co1, s1} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL w1_sum%0d got ov=%b cout/sum=%b%b want 1 %b", i, ov1, co1, s1, exp);
      end
      step();
    end
  endtask

  task automatic test_random16;
    logic [16:0] exp_q[$];
    int          due_q[$];
    int cyc = 0, accepts = 0, outs = 0;
    while (outs < 1000 && cyc < 40000) begin
      step();
      cyc++;
      if (ov16 === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra_pulse got out_valid at cycle %0d want none", cyc);
        end else begin
          if ({co16, s16} !== exp_q[0] || cyc != due_q[0]) begin
            n_fail++;
            $display("FAIL rnd_result%0d got %h at cycle %0d want %h at cycle %0d",
                     outs, {co16, s16}, cyc, exp_q[0], due_q[0]);
          end
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        outs++;
      end
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom);
      iv16 = (accepts < 1000) && ($urandom_range(0, 3) != 0);
      if (iv16 && ir16 === 1'b1) begin
        exp_q.push_back({1'b0, a16} + {1'b0, b16} + {16'h0000, cin16});
        due_q.push_back(cyc + 17);
        accepts++;
      end
    end
    iv16 = 1'b0;
    n_tests++;
    if (outs != 1000 || accepts != 1000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_count got accepts=%0d results=%0d pending=%0d want 1000 1000 0",
               accepts, outs, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    test_width1();
    test_random16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller that time-shares one 1-bit full-adder cell to add two WIDTH-bit operands, LSB first, one bit per clock. Accepts operands through a valid/ready handshake, sequences the cell for WIDTH cycles through a carry flip-flop, and presents sum/carry-out with a one-cycle valid pulse. Used where area matters more than latency, in front of or in place of a ripple adder in the arithmetic datapath.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..64; elaboration error outside this range.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, cin valid this cycle
in_ready  output  1  controller can accept operands this cycle
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
cin  input  1  carry-in, sampled on accept
out_valid  output  1  one-cycle pulse; sum/cout valid
sum  output  WIDTH  result bits, held until next accept completes
cout  output  1  final carry-out, held with sum
busy  output  1  high while addition in progress (RUN state)

Behaviour:
- Single clock domain. Reset is synchronous, active-high. Reset wins over all other inputs.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, bit counter=0, carry FF=0, operand shift registers=0.
- States:
  - IDLE: in_ready=1. Accept (in_valid & in_ready) -> RUN.
  - RUN: in_ready=0, busy=1. Advance one bit per cycle. After WIDTH bits -> DONE.
  - DONE: out_valid=1 for exactly this cycle, in_ready=1. Accept -> RUN; otherwise -> IDLE.
- On accept edge:
  - Load A and B into shift registers; load carry FF with cin; clear counter.
  - sum/cout keep their previous values until the new operation finishes.
- RUN, each edge:
  - Full-adder cell inputs are A_sr[0], B_sr[0] and the carry FF.
  - Cell sum bit shifts into the MSB of the sum shift register; the sum register shifts right.
  - Carry FF takes the cell carry. A_sr and B_sr shift right. Counter increments.
  - After the edge where counter = WIDTH-1: state -> DONE and cout = carry FF value.
- Latency: out_valid is high in the cycle following the WIDTH-th RUN edge, i.e. WIDTH+1 edges after the accept edge.
- Throughput: one result per WIDTH+1 cycles with back-to-back accepts in DONE.
- Result: {cout, sum} = a + b + cin, exact modulo 2^(WIDTH+1). No overflow flag.
- in_valid during RUN is ignored. Upstream must hold it; no operand capture occurs.
- Accept in DONE: out_valid still pulses that cycle, showing the previous result. The new operands load on the same edge.
- WIDTH=1: RUN lasts exactly one cycle. Counter width is max(1, $clog2(WIDTH)).
- Reset mid-RUN: abort. Next cycle is IDLE with all reset values and no out_valid; the partial result is discarded.
- sum/cout change only on reset or on the edge entering DONE.
- busy = (state==RUN).

Decomposition:
- Shared arithmetic package:
  - state enum type (IDLE, RUN, DONE) as 2-bit typedef
  - WIDTH legal-range constants
- One sub-module is natural: fa_cell, a purely combinational 1-bit full adder. Outputs: s = a^b^c, co = (a&b)|((a^b)&c). Instantiated once; all sequencing lives in serial_add_ctrl.

Test Plan:
1. WIDTH=8; after rst, accept a=0x5A, b=0x3C, cin=0 -> out_valid pulses 9 edges later with sum=0x96, cout=0; in_ready=0 and busy=1 for exactly 8 cycles.
2. WIDTH=8; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
3. WIDTH=8; accept 0x10+0x20, hold in_valid with 0x01+0x01 during RUN -> first result sum=0x30, cout=0. The second set is accepted in the DONE cycle, where out_valid=1 and in_ready=1 coincide, and returns sum=0x02 exactly 9 edges later.
4. WIDTH=8; accept 0xAA+0x55, assert rst after 3 RUN cycles -> next cycle: IDLE, in_ready=1, busy=0, sum=0x00, cout=0, no out_valid pulse ever appears. A fresh 0x01+0x02 then gives sum=0x03.
5. WIDTH=1; exhaustive 8 combinations of {a, b, cin} -> {cout, sum} equals their arithmetic sum; out_valid 2 edges after each accept.
6. WIDTH=16 random regression, 1000 operations with random in_valid gaps -> every {cout, sum} matches the reference model a+b+cin; exactly one out_valid per accept.
